// File: rtl/ecc_mem_scrubber_pkg.sv
// Shared widths, the SECDED data-bit position table, the encoder and the
// scrubber FSM state type.
package ecc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 7;
  localparam int unsigned CW_W   = DATA_W + CHK_W;
  localparam int unsigned HAM_W  = CHK_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_WRITE,
    ST_ADVANCE
  } state_t;

  // Hamming position of data bit k: the non-powers-of-two from 3 to 38
  localparam logic [HAM_W-1:0] P_TAB [DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  function automatic logic [HAM_W-1:0] hamming_chk(input logic [DATA_W-1:0] d);
    logic [HAM_W-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      for (int unsigned i = 0; i < HAM_W; i++) begin
        if (P_TAB[k][i]) c[i] = c[i] ^ d[k];
      end
    end
    return c;
  endfunction

  function automatic logic [CW_W-1:0] secded_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-2:0] w;
    w = {hamming_chk(d), d};
    return {^w, w};
  endfunction

endpackage

// File: rtl/ecc_mem_scrubber_dec.sv
// Combinational SECDED (39,32) decoder: returns the corrected codeword and
// flags correctable / uncorrectable errors.
module secded_39_32_dec
  import ecc_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  output logic [CW_W-1:0] fixed,
  output logic            ce,
  output logic            ue
);

  logic [HAM_W-1:0] syn;
  logic             q;
  logic [CW_W-1:0]  flip;

  always_comb begin
    syn  = hamming_chk(cw[DATA_W-1:0]) ^ cw[CW_W-2:DATA_W];
    q    = ^cw;
    flip = '0;
    ce   = 1'b0;
    ue   = 1'b0;
    if (q) begin
      if (syn == '0) flip[CW_W-1] = 1'b1;
      for (int unsigned i = 0; i < HAM_W; i++) begin
        if (syn == HAM_W'(1 << i)) flip[DATA_W + i] = 1'b1;
      end
      for (int unsigned k = 0; k < DATA_W; k++) begin
        if (syn == P_TAB[k]) flip[k] = 1'b1;
      end
      // odd parity with a syndrome that maps nowhere (>38) is uncorrectable
      ce = |flip;
      ue = ~|flip;
    end else if (syn != '0) begin
      ue = 1'b1;
    end
    fixed = cw ^ flip;
  end

endmodule

// File: rtl/ecc_mem_scrubber.sv
// Background SECDED scrubber for the 39-bit data memory port.
// Optional SCRUB_UE_HALT_EN: halt in IDLE after an uncorrectable error until scrub_en toggles.
module ecc_mem_scrubber
  import ecc_pkg::*;
#(
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned SCRUB_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scrub_en,
  input  logic              core_busy,
  output logic              scrub_sel,
  output logic [31:0]       scrub_A,
  output logic              scrub_WE,
  output logic [CW_W-1:0]   scrub_WD,
  input  logic [CW_W-1:0]   mem_RD,
  output logic [15:0]       ce_count,
  output logic [15:0]       ue_count,
  output logic              ue_flag,
  output logic [ADDR_W-1:0] ue_addr,
  output logic              pass_done
);

  localparam int unsigned CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SCRUB_INTERVAL - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              sel_q;
  logic              we_q;
  logic [CW_W-1:0]   wd_q;
  logic              ce_logged;
  logic [CW_W-1:0]   dec_fixed;
  logic              dec_ce;
  logic              dec_ue;
`ifdef SCRUB_UE_HALT_EN
  logic              halted;
`endif

  secded_39_32_dec u_dec (
    .cw    (mem_RD),
    .fixed (dec_fixed),
    .ce    (dec_ce),
    .ue    (dec_ue)
  );

  // core always wins the port; reset kills an in-flight write in its own cycle
  assign scrub_sel = sel_q & ~core_busy & rst;
  assign scrub_WE  = we_q & ~core_busy & rst;
  assign scrub_WD  = wd_q;
  assign scrub_A   = {{(32 - ADDR_W){1'b0}}, addr};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      wait_cnt  <= '0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      ce_logged <= 1'b0;
      ce_count  <= '0;
      ue_count  <= '0;
      ue_flag   <= 1'b0;
      ue_addr   <= '0;
      pass_done <= 1'b0;
`ifdef SCRUB_UE_HALT_EN
      halted    <= 1'b0;
`endif
    end else begin
      pass_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          sel_q     <= 1'b0;
          we_q      <= 1'b0;
          wait_cnt  <= '0;
          ce_logged <= 1'b0;
`ifdef SCRUB_UE_HALT_EN
          if (!scrub_en) halted <= 1'b0;
          else if (!halted) state <= ST_WAIT;
`else
          if (scrub_en) state <= ST_WAIT;
`endif
        end
        ST_WAIT: begin
          if (!scrub_en) begin
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end else if (wait_cnt == LAST_CNT) begin
            wait_cnt <= '0;
            sel_q    <= 1'b1;
            state    <= ST_READ;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_READ: begin
          if (!scrub_en) begin
            sel_q     <= 1'b0;
            ce_logged <= 1'b0;
            state     <= ST_IDLE;
          end else if (!core_busy) begin
            if (dec_ce) begin
              wd_q  <= dec_fixed;
              we_q  <= 1'b1;
              state <= ST_WRITE;
              // a re-read after a pre-empted write must not count the same error twice
              if (!ce_logged) begin
                ce_logged <= 1'b1;
                if (ce_count != '1) ce_count <= ce_count + 16'd1;
              end
            end else begin
              sel_q     <= 1'b0;
              ce_logged <= 1'b0;
              state     <= ST_ADVANCE;
              if (dec_ue) begin
                if (ue_count != '1) ue_count <= ue_count + 16'd1;
                ue_flag <= 1'b1;
                ue_addr <= addr;
`ifdef SCRUB_UE_HALT_EN
                halted  <= 1'b1;
`endif
              end
            end
          end
        end
        ST_WRITE: begin
          we_q <= 1'b0;
          if (core_busy) begin
            state <= ST_READ;
          end else begin
            sel_q     <= 1'b0;
            ce_logged <= 1'b0;
            state     <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          if (addr == LAST_ADDR) begin
            addr      <= '0;
            pass_done <= 1'b1;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
`ifdef SCRUB_UE_HALT_EN
          state <= halted ? ST_IDLE : ST_WAIT;
`else
          state <= ST_WAIT;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
